quad_decoder: RTL and testbench

Quadrature front end that turns two raw encoder phases (A, B) into the single-cycle count-enable and direction pair consumed by `counter_dir`. Each phase is synchronised, glitch-filtered and then decoded by a 4-state Gray-code tracker. Every legal edge produces one `ce` pulse with a matching `dir` level. An illegal double transition raises a sticky error flag instead of a pulse. The block sits directly upstream of `counter_dir`: its `ce`/`dir` outputs drive that counter's `ce`/`dir` inputs.

---
 rtl/quad_decoder.sv | 126 ++++++++++++
 tb/tb_quad_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature front end: synchronises and glitch-filters phases A/B, then tracks the
// Gray-code state to emit a one-cycle count enable, a direction level and a sticky error.
module quad_decoder #(
    parameter int FILT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic en,
    input  logic clr_err,
    output logic ce,
    output logic dir,
    output logic err
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    logic [1:0] raw;
    logic [1:0] lvl_cur;
    logic [1:0] lvl_nxt;

    // Bit 1 is phase A, bit 0 is phase B, so the state reads as {af, bf}.
    assign raw = {a, b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_phase
            logic          s1_reg;
            logic          s2_reg;
            logic          lvl_reg;
            logic          lvl_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            always_comb begin
                lvl_next = lvl_reg;
                cnt_next = cnt_reg;
                if (s2_reg == lvl_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    lvl_next = s2_reg;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg  <= 1'b0;
                    s2_reg  <= 1'b0;
                    lvl_reg <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    s1_reg  <= raw[gi];
                    s2_reg  <= s1_reg;
                    lvl_reg <= lvl_next;
                    cnt_reg <= cnt_next;
                end
            end

            assign lvl_cur[gi] = lvl_reg;
            assign lvl_nxt[gi] = lvl_next;
        end
    endgenerate

    // Successor of a state along the up sequence 00->10->11->01->00.
    function automatic logic [1:0] up_of(input logic [1:0] s);
        case (s)
            2'b00:   up_of = 2'b10;
            2'b10:   up_of = 2'b11;
            2'b11:   up_of = 2'b01;
            default: up_of = 2'b00;
        endcase
    endfunction

    logic step_up;
    logic step_dn;
    logic step_both;
    logic ce_reg, ce_next;
    logic dir_reg, dir_next;
    logic err_reg, err_next;

    assign step_up   = (lvl_nxt == up_of(lvl_cur));
    assign step_dn   = (lvl_cur == up_of(lvl_nxt));
    assign step_both = ((lvl_cur ^ lvl_nxt) == 2'b11);

    always_comb begin
        ce_next  = 1'b0;
        dir_next = dir_reg;
        if (step_up) begin
            ce_next = en;
            if (en) dir_next = 1'b1;
        end else if (step_dn) begin
            ce_next = en;
            if (en) dir_next = 1'b0;
        end
    end

    // A new illegal step wins over a simultaneous clear.
    always_comb begin
        err_next = err_reg;
        if (step_both && en)
            err_next = 1'b1;
        else if (clr_err)
            err_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_reg  <= 1'b0;
            dir_reg <= 1'b1;
            err_reg <= 1'b0;
        end else begin
            ce_reg  <= ce_next;
            dir_reg <= dir_next;
            err_reg <= err_next;
        end
    end

    assign ce  = ce_reg;
    assign dir = dir_reg;
    assign err = err_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: each driven phase step queues the expected pulse
// cycle and direction; a negedge monitor pops and compares every observed ce pulse.
module tb_quad_decoder;

    localparam int FILT = 4;
    localparam int LAT  = 2 + FILT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b1;
    logic b = 1'b1;
    logic en = 1'b1;
    logic clr_err = 1'b0;
    logic ce, dir, err;

    typedef struct {
        bit dir;
        int cyc;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   seen = 0;
    int   pushed = 0;
    int   q = 0;

    quad_decoder #(.FILT(FILT)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
        .clr_err(clr_err), .ce(ce), .dir(dir), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
        end else begin
            $display("ok   %s got=%0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ce) begin
            if (expq.size() == 0) begin
                check("spurious_ce", ce, 0);
            end else begin
                e = expq.pop_front();
                check("ce_cycle", cyc, e.cyc);
                check("ce_dir", dir, e.dir);
                seen++;
                q = dir ? (q + 1) % 8 : (q + 7) % 8;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 = no pulse expected, 1 = up, 2 = down
    task automatic step(input bit na, input bit nb, input int kind);
        a = na;
        b = nb;
        if (kind != 0) begin
            expq.push_back('{dir: (kind == 1), cyc: cyc + LAT});
            pushed++;
        end
        tick(8);
    endtask

    initial begin
        bit got_err;
        tick(1);
        // Reset held with both pins high: outputs must stay at reset values
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_dir", dir, 1);
            check("rst_err", err, 0);
        end
        tick(1);
        rst = 1'b0;
        got_err = 1'b0;
        for (int i = 0; i < FILT + 3 && !got_err; i++) begin
            @(negedge clk);
            got_err = err;
        end
        check("rst_jump_err", got_err, 1);
        check("rst_jump_dir", dir, 1);
        tick(4);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("err_cleared", err, 0);

        // Walk 11 back to 00 along the up sequence
        step(0, 1, 1);
        step(0, 0, 1);

        // Forward: three full up cycles, 12 steps
        q = 0;
        for (int r = 0; r < 3; r++) begin
            step(1, 0, 1);
            step(1, 1, 1);
            step(0, 1, 1);
            step(0, 0, 1);
        end
        check("cnt_fwd", q, 4);

        // Reverse: four down steps
        step(0, 1, 2);
        step(1, 1, 2);
        step(1, 0, 2);
        step(0, 0, 2);
        check("cnt_rev", q, 0);

        // Glitch: 3-cycle pulse rejected, 4-cycle pulse gives up then down
        a = 1'b1;
        tick(3);
        a = 1'b0;
        tick(10);
        a = 1'b1;
        expq.push_back('{dir: 1'b1, cyc: cyc + LAT});
        pushed++;
        tick(4);
        a = 1'b0;
        expq.push_back('{dir: 1'b0, cyc: cyc + LAT});
        pushed++;
        tick(10);

        // Illegal double transition
        step(1, 1, 0);
        check("illegal_err", err, 1);
        check("illegal_dir", dir, 0);
        a = 1'b0;
        b = 1'b0;
        tick(5);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("set_beats_clr", err, 1);
        tick(3);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_alone", err, 0);

        // Enable low: steps tracked silently, no catch-up pulse
        en = 1'b0;
        step(1, 0, 0);
        step(1, 1, 0);
        en = 1'b1;
        tick(8);
        check("en_dir_hold", dir, 0);
        step(0, 1, 1);
        step(0, 0, 1);

        // Reset two cycles into a filter count; the step restarts after release
        a = 1'b1;
        tick(3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ce", ce, 0);
        check("midrst_dir", dir, 1);
        tick(1);
        rst = 1'b0;
        expq.push_back('{dir: 1'b1, cyc: cyc + LAT});
        pushed++;
        tick(12);
        check("midrst_err", err, 0);

        check("pending", expq.size(), 0);
        check("pulse_count", seen, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
